// File: rtl/startstop_pkg.sv
// startstop_pkg: default parameters and debounce counter width helper
package startstop_pkg;
  localparam int SYNC_STAGES_DEF = 2;
  localparam int DEBOUNCE_CYCLES_DEF = 1;
  function automatic int cnt_w(input int d);
    return $clog2(d + 1);
  endfunction
endpackage

// File: rtl/key_debounce.sv
// key_debounce: KEY synchronizer, debounce filter, rise detector (CLK, RST, KEY -> key_db level, press_pulse)
module key_debounce
  import startstop_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY,
  output logic key_db,
  output logic press_pulse
);
  localparam int CNT_W = cnt_w(DEBOUNCE_CYCLES);
  logic [SYNC_STAGES-1:0] r_sync;
  logic [CNT_W-1:0] r_cnt;
  logic r_key_db;
  logic w_key_s;
  logic w_agree;
  logic w_hit;
  assign w_key_s = r_sync[SYNC_STAGES-1];
  assign w_agree = w_key_s == r_key_db;
  // the mismatch has lasted DEBOUNCE_CYCLES edges including this one
  assign w_hit = !w_agree && r_cnt == CNT_W'(DEBOUNCE_CYCLES - 1);
  // combinational so the toggle lands on the same edge key_db rises
  assign press_pulse = w_hit && w_key_s;
  assign key_db = r_key_db;
  always_ff @(posedge CLK) begin
    if (RST) begin
      r_sync <= '0;
      r_cnt <= '0;
      r_key_db <= 1'b0;
    end else begin
      r_sync <= {r_sync[SYNC_STAGES-2:0], KEY};
      r_cnt <= (w_agree || w_hit) ? '0 : r_cnt + CNT_W'(1);
      r_key_db <= w_hit ? w_key_s : r_key_db;
    end
  end
endmodule

// File: rtl/startstop_toggle.sv
// startstop_toggle: push-button run/stop latch toggled per debounced press (CLK, RST, KEY -> startstop)
module startstop_toggle
  import startstop_pkg::*;
#(
  parameter int SYNC_STAGES = SYNC_STAGES_DEF,
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEF
) (
  input  logic CLK,
  input  logic RST,
  input  logic KEY,
  output logic startstop
);
  logic w_key_db;
  logic w_press;
  logic r_run;
  key_debounce #(
    .SYNC_STAGES(SYNC_STAGES),
    .DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)
  ) u_deb (
    .CLK(CLK),
    .RST(RST),
    .KEY(KEY),
    .key_db(w_key_db),
    .press_pulse(w_press)
  );
  always_ff @(posedge CLK) begin
    if (RST) r_run <= 1'b0;
    else if (w_press) r_run <= ~r_run;
  end
  assign startstop = r_run;
  // a press can only come from a debounced level that is still low
  a_press_from_low: assert property (@(posedge CLK) disable iff (RST) w_press |-> !w_key_db);
endmodule

// File: tb/tb_startstop_toggle.sv
// tb_startstop_toggle: directed table plus hand sequences for startstop_toggle
module tb_startstop_toggle;
  logic clk = 1'b0;
  logic rst = 1'b1;
  logic key = 1'b0;
  logic key4 = 1'b0;
  logic ss;
  logic ss4;
  int n_tests = 0;
  int n_fail = 0;
  typedef struct {
    logic rst;
    logic key;
    logic exp;
  } vec_t;
  vec_t tbl[25];
  always #10 clk = ~clk;
  startstop_toggle dut (.CLK(clk), .RST(rst), .KEY(key), .startstop(ss));
  startstop_toggle #(.SYNC_STAGES(2), .DEBOUNCE_CYCLES(4)) dut4 (.CLK(clk), .RST(rst), .KEY(key4), .startstop(ss4));
  task automatic cyc(input logic r, input logic k, input logic k4);
    @(negedge clk);
    rst = r;
    key = k;
    key4 = k4;
    @(posedge clk);
    #1;
  endtask
  task automatic chk(input string name, input logic act, input logic exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %b expected %b at %0t", name, act, exp, $time);
    end
  endtask
  initial begin
    int toggles;
    logic prev;
    tbl[0] = '{1, 1, 0};
    tbl[1] = '{1, 1, 0};
    tbl[2] = '{0, 1, 0};
    tbl[3] = '{0, 1, 0};
    tbl[4] = '{0, 1, 1};
    for (int i = 5; i < 10; i++) tbl[i] = '{0, 0, 1};
    tbl[10] = '{0, 1, 1};
    tbl[11] = '{0, 0, 1};
    tbl[12] = '{0, 0, 0};
    tbl[13] = '{0, 0, 0};
    tbl[14] = '{0, 0, 0};
    tbl[15] = '{0, 1, 0};
    tbl[16] = '{0, 0, 0};
    tbl[17] = '{0, 1, 1};
    tbl[18] = '{0, 0, 1};
    tbl[19] = '{0, 1, 0};
    tbl[20] = '{0, 0, 0};
    tbl[21] = '{0, 1, 1};
    tbl[22] = '{0, 0, 1};
    tbl[23] = '{0, 0, 0};
    tbl[24] = '{0, 0, 0};
    for (int i = 0; i < 25; i++) begin
      cyc(tbl[i].rst, tbl[i].key, 1'b0);
      chk($sformatf("table[%0d]", i), ss, tbl[i].exp);
    end
    chk("dut4_idle", ss4, 1'b0);
    toggles = 0;
    prev = ss;
    for (int i = 0; i < 50; i++) begin
      cyc(0, 1, 0);
      if (ss !== prev) toggles++;
      prev = ss;
    end
    chk("held_value", ss, 1'b1);
    n_tests++;
    if (toggles != 1) begin
      n_fail++;
      $display("FAIL held_toggles: got %0d expected 1", toggles);
    end
    for (int i = 0; i < 5; i++) cyc(0, 0, 0);
    chk("held_release", ss, 1'b1);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    chk("repress_lag1", ss, 1'b1);
    cyc(0, 0, 0);
    chk("repress_toggle", ss, 1'b0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("midrun_set", ss, 1'b1);
    cyc(1, 0, 0);
    chk("midrun_reset", ss, 1'b0);
    for (int i = 0; i < 3; i++) cyc(0, 0, 0);
    chk("after_reset_idle", ss, 1'b0);
    cyc(0, 1, 0);
    cyc(0, 0, 0);
    cyc(0, 0, 0);
    chk("after_reset_press", ss, 1'b1);
    for (int i = 0; i < 3; i++) cyc(0, 0, 1);
    for (int i = 0; i < 8; i++) begin
      cyc(0, 0, 0);
      chk($sformatf("glitch3[%0d]", i), ss4, 1'b0);
    end
    for (int i = 1; i <= 8; i++) begin
      cyc(0, 0, 1);
      if (i == 5) chk("deb4_lag", ss4, 1'b0);
      if (i == 6) chk("deb4_toggle", ss4, 1'b1);
    end
    for (int i = 0; i < 5; i++) begin
      cyc(0, 0, logic'(i[0]));
      chk($sformatf("bounce[%0d]", i), ss4, 1'b1);
    end
    for (int i = 0; i < 8; i++) cyc(0, 0, 0);
    chk("bounce_settle", ss4, 1'b1);
    for (int i = 1; i <= 6; i++) begin
      cyc(0, 0, i <= 4);
      if (i == 5) chk("deb4_repress_lag", ss4, 1'b1);
      if (i == 6) chk("deb4_repress", ss4, 1'b0);
    end
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end
endmodule
